alu_rsv_station: RTL and testbench

Reservation station feeding the 2-stage ALU pipeline. Holds dispatched ALU/branch `instruction_t` packets until all source operands are available. Captures operand data from CDB broadcasts and issues the oldest ready entry to the ALU whenever `alu_rdy` is high. Sits between dispatch/rename and `alu`.

---
 rtl/uarch_pkg.sv | 48 ++++
 rtl/rs_age_select.sv | 54 +++++
 rtl/alu_rsv_station.sv | 139 +++++++++++++
 tb/tb_alu_rsv_station.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uarch_pkg.sv
// Shared micro-architecture types: rename tags, source operand slots,
// dispatch/issue packets and CDB writeback packets.
package uarch_pkg;

  localparam int TAG_WIDTH    = 6;
  localparam int XLEN         = 32;
  localparam int ALU_RS_DEPTH = 8;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_BEQ = 4'd5,
    ALU_BNE = 4'd6
  } alu_op_e;

  // is_renamed = 1 means data is not yet valid and the slot waits on tag
  typedef struct packed {
    logic [XLEN-1:0]      data;
    logic [TAG_WIDTH-1:0] tag;
    logic                 is_renamed;
  } src_slot_t;

  typedef struct packed {
    logic                 is_valid;
    alu_op_e              opcode;
    logic [TAG_WIDTH-1:0] dest_tag;
    src_slot_t            src_0_a;
    src_slot_t            src_0_b;
    src_slot_t            src_1_a;
    src_slot_t            src_1_b;
  } instruction_t;

  typedef struct packed {
    logic                 is_valid;
    logic [TAG_WIDTH-1:0] dest_tag;
    logic [XLEN-1:0]      result;
  } writeback_packet_t;

  // True when no source slot is still waiting on a broadcast
  function automatic logic operands_ready(input instruction_t p);
    return !p.src_0_a.is_renamed && !p.src_0_b.is_renamed &&
           !p.src_1_a.is_renamed && !p.src_1_b.is_renamed;
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Age matrix for the reservation station: remembers allocation order of
// resident entries and grants the oldest ready one (one-hot).
module rs_age_select #(
  parameter int RS_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [RS_DEPTH-1:0] alloc,
  input  logic [RS_DEPTH-1:0] free,
  input  logic [RS_DEPTH-1:0] ready,
  output logic [RS_DEPTH-1:0] grant
);

  // older_q[i][j] = 1: entry j is resident and was allocated before entry i
  logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] older_d [RS_DEPTH];
  logic [RS_DEPTH-1:0] valid_q;
  logic [RS_DEPTH-1:0] valid_d;

  // Next matrix: freed entries drop out of every row, a new entry is younger
  // than everything that stays resident
  always_comb begin
    valid_d = (valid_q & ~free) | alloc;
    for (int i = 0; i < RS_DEPTH; i++) begin
      older_d[i] = older_q[i] & ~free;
      if (free[i])  older_d[i] = '0;
      if (alloc[i]) older_d[i] = valid_q & ~free;
    end
    if (flush) begin
      valid_d = '0;
      for (int i = 0; i < RS_DEPTH; i++) older_d[i] = '0;
    end
  end

  // Matrix and residency registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) older_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < RS_DEPTH; i++) older_q[i] <= older_d[i];
    end
  end

  // Grant a ready entry that has no older ready entry
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      grant[i] = ready[i] && ((older_q[i] & ready) == '0);
    end
  end

endmodule

// File: rtl/alu_rsv_station.sv
// ALU reservation station: buffers dispatched packets, snoops the CDB for
// operand wakeup and issues the oldest ready entry to the ALU.
// Handshakes: a dispatch transfers when rs_packet.is_valid && rs_rdy at a
// posedge; an issue transfers when alu_packet.is_valid, which is only ever
// raised while alu_rdy is high, so the ALU must take it that cycle.
module alu_rsv_station
  import uarch_pkg::*;
#(
  parameter int RS_DEPTH = ALU_RS_DEPTH,
  parameter int NUM_CDB  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  instruction_t                      rs_packet,
  output logic                              rs_rdy,
  input  writeback_packet_t [NUM_CDB-1:0]   cdb,
  output instruction_t                      alu_packet,
  input  logic                              alu_rdy
);

  localparam int CNT_W = $clog2(RS_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RS_DEPTH);

  instruction_t        entries_q [RS_DEPTH];
  instruction_t        entries_d [RS_DEPTH];
  logic [CNT_W-1:0]    count_q, count_d;
  logic [RS_DEPTH-1:0] ready_vec, grant, alloc_oh, free_oh;
  logic                dispatch_fire, issue_fire, any_ready;
  instruction_t        issue_pkt;

  // Lower CDB port wins when two ports carry the same tag
  function automatic src_slot_t wake_slot(input src_slot_t s,
                                          input writeback_packet_t [NUM_CDB-1:0] bus);
    src_slot_t r;
    logic      hit;
    r   = s;
    hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (!hit && s.is_renamed && bus[k].is_valid && bus[k].dest_tag == s.tag) begin
        r.data       = bus[k].result;
        r.is_renamed = 1'b0;
        hit          = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic instruction_t wake_pkt(input instruction_t p,
                                            input writeback_packet_t [NUM_CDB-1:0] bus);
    instruction_t r;
    r         = p;
    r.src_0_a = wake_slot(p.src_0_a, bus);
    r.src_0_b = wake_slot(p.src_0_b, bus);
    r.src_1_a = wake_slot(p.src_1_a, bus);
    r.src_1_b = wake_slot(p.src_1_b, bus);
    return r;
  endfunction

  // Space check uses registered occupancy only; an issue this cycle does not help
  assign rs_rdy        = !rst && (count_q < DEPTH_C);
  assign dispatch_fire = rs_packet.is_valid && rs_rdy && !flush;

  rs_age_select #(
    .RS_DEPTH (RS_DEPTH)
  ) u_age (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .alloc (alloc_oh),
    .free  (free_oh),
    .ready (ready_vec),
    .grant (grant)
  );

  // Ready vector from registered state and issue mux (no CDB path to alu_packet)
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready_vec[i] = entries_q[i].is_valid && operands_ready(entries_q[i]);
    end
    any_ready  = |ready_vec;
    issue_fire = alu_rdy && any_ready && !flush && !rst;
    issue_pkt  = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grant[i]) issue_pkt = entries_q[i];
    end
    alu_packet = '0;
    if (issue_fire) begin
      alu_packet          = issue_pkt;
      alu_packet.is_valid = 1'b1;
    end
    free_oh = issue_fire ? grant : '0;
  end

  // Allocate the lowest-index free entry
  always_comb begin
    logic found;
    found    = 1'b0;
    alloc_oh = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!found && !entries_q[i].is_valid) begin
        alloc_oh[i] = dispatch_fire;
        found       = 1'b1;
      end
    end
  end

  // Entry update: free on issue, wake resident slots, write bypassed dispatch
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (free_oh[i]) begin
        entries_d[i] = '0;
      end else if (entries_q[i].is_valid) begin
        entries_d[i] = wake_pkt(entries_q[i], cdb);
      end
      if (alloc_oh[i]) begin
        entries_d[i]          = wake_pkt(rs_packet, cdb);
        entries_d[i].is_valid = 1'b1;
      end
      if (flush) entries_d[i] = '0;
    end
    count_d = count_q + {{(CNT_W-1){1'b0}}, dispatch_fire}
                      - {{(CNT_W-1){1'b0}}, issue_fire};
    if (flush) count_d = '0;
  end

  // Entry storage and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < RS_DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

endmodule

// File: tb/tb_alu_rsv_station.sv
// Self-checking bench for alu_rsv_station: directed scenarios plus random
// traffic, all checked against an age-ordered queue model of the station.
module tb_alu_rsv_station;
  import uarch_pkg::*;

  localparam int RS_DEPTH = 8;
  localparam int NUM_CDB  = 2;
  localparam int PKT_W    = $bits(instruction_t);

  logic                            clk;
  logic                            rst;
  logic                            flush;
  instruction_t                    rs_packet;
  logic                            rs_rdy;
  writeback_packet_t [NUM_CDB-1:0] cdb;
  instruction_t                    alu_packet;
  logic                            alu_rdy;

  int checks = 0;
  int errors = 0;

  // Model: resident packets, oldest first; expected issues queue
  instruction_t     mdl_q[$];
  logic [PKT_W-1:0] exp_q[$];
  instruction_t     obs_pkt;
  logic             obs_rdy;

  alu_rsv_station #(
    .RS_DEPTH (RS_DEPTH),
    .NUM_CDB  (NUM_CDB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .rs_packet  (rs_packet),
    .rs_rdy     (rs_rdy),
    .cdb        (cdb),
    .alu_packet (alu_packet),
    .alu_rdy    (alu_rdy)
  );

  // Clock and global time limit
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach its summary, got running exp finished");
    $fatal(1, "timeout");
  end

  function automatic src_slot_t m_wake(input src_slot_t s);
    if (!s.is_renamed) return s;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb[k].is_valid && cdb[k].dest_tag == s.tag) begin
        s.data       = cdb[k].result;
        s.is_renamed = 1'b0;
        return s;
      end
    end
    return s;
  endfunction

  function automatic instruction_t m_wake_pkt(input instruction_t p);
    p.src_0_a = m_wake(p.src_0_a);
    p.src_0_b = m_wake(p.src_0_b);
    p.src_1_a = m_wake(p.src_1_a);
    p.src_1_b = m_wake(p.src_1_b);
    return p;
  endfunction

  function automatic logic m_ready(input instruction_t p);
    return !(p.src_0_a.is_renamed || p.src_0_b.is_renamed ||
             p.src_1_a.is_renamed || p.src_1_b.is_renamed);
  endfunction

  function automatic instruction_t mk_pkt(input alu_op_e op, input logic [31:0] a,
                                          input logic [31:0] b);
    instruction_t p;
    p              = '0;
    p.is_valid     = 1'b1;
    p.opcode       = op;
    p.dest_tag     = 6'd1;
    p.src_0_a.data = a;
    p.src_0_b.data = b;
    return p;
  endfunction

  function automatic src_slot_t rand_slot();
    src_slot_t s;
    s.data       = $urandom;
    s.tag        = 6'($urandom_range(0, 7));
    s.is_renamed = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  function automatic instruction_t rand_pkt();
    instruction_t p;
    p.is_valid = 1'b1;
    p.opcode   = alu_op_e'(4'($urandom_range(0, 6)));
    p.dest_tag = 6'($urandom_range(0, 63));
    p.src_0_a  = rand_slot();
    p.src_0_b  = rand_slot();
    p.src_1_a  = rand_slot();
    p.src_1_b  = rand_slot();
    return p;
  endfunction

  task automatic drive_idle();
    rs_packet = '0;
    cdb       = '0;
    flush     = 1'b0;
    rst       = 1'b0;
  endtask

  // One cycle: sample outputs before the posedge, score them against the
  // model, advance the model with this cycle's inputs, move to next negedge
  task automatic tick();
    int           hit;
    logic         exp_rdy;
    logic         disp;
    instruction_t e;
    #1;
    obs_pkt = alu_packet;
    obs_rdy = rs_rdy;
    exp_rdy = !rst && (mdl_q.size() < RS_DEPTH);
    hit     = -1;
    if (alu_rdy && !flush && !rst) begin
      for (int i = 0; i < mdl_q.size(); i++) begin
        if (hit < 0 && m_ready(mdl_q[i])) hit = i;
      end
    end
    if (hit >= 0) exp_q.push_back(mdl_q[hit]);

    checks++;
    if (obs_rdy !== exp_rdy) begin
      errors++;
      $display("FAIL rs_rdy t=%0t got %b exp %b", $time, obs_rdy, exp_rdy);
    end
    checks++;
    if (obs_pkt.is_valid !== (hit >= 0)) begin
      errors++;
      $display("FAIL issue_valid t=%0t got %b exp %b", $time, obs_pkt.is_valid, (hit >= 0));
      exp_q.delete();
    end else if (obs_pkt.is_valid === 1'b1) begin
      e = instruction_t'(exp_q.pop_front());
      checks++;
      if (obs_pkt !== e) begin
        errors++;
        $display("FAIL issue_pkt t=%0t got %h exp %h", $time, obs_pkt, e);
      end
    end else begin
      checks++;
      if (obs_pkt !== '0) begin
        errors++;
        $display("FAIL idle_zero t=%0t got %h exp 0", $time, obs_pkt);
      end
    end

    if (rst || flush) begin
      mdl_q.delete();
    end else begin
      disp = rs_packet.is_valid && (mdl_q.size() < RS_DEPTH);
      if (hit >= 0) mdl_q.delete(hit);
      foreach (mdl_q[i]) mdl_q[i] = m_wake_pkt(mdl_q[i]);
      if (disp) mdl_q.push_back(m_wake_pkt(rs_packet));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_idle();
    rst       = 1'b1;
    alu_rdy   = 1'b1;
    rs_packet = mk_pkt(ALU_ADD, 32'd1, 32'd2);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs_rdy !== 1'b0 || obs_pkt !== '0) begin
        errors++;
        $display("FAIL reset_outputs got rdy=%b pkt=%h exp rdy=0 pkt=0", obs_rdy, obs_pkt);
      end
    end
    drive_idle();
    tick();
    checks++;
    if (obs_rdy !== 1'b1 || obs_pkt.is_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset got rdy=%b valid=%b exp rdy=1 valid=0", obs_rdy, obs_pkt.is_valid);
    end
  endtask

  task automatic test_ready_dispatch();
    alu_rdy   = 1'b1;
    rs_packet = mk_pkt(ALU_ADD, 32'd5, 32'd7);
    tick();
    drive_idle();
    tick();
    checks++;
    if (obs_pkt.is_valid !== 1'b1 || obs_pkt.src_0_a.data !== 32'd5 ||
        obs_pkt.src_0_b.data !== 32'd7 || obs_pkt.opcode !== ALU_ADD) begin
      errors++;
      $display("FAIL ready_dispatch got v=%b a=%h b=%h exp v=1 a=5 b=7",
               obs_pkt.is_valid, obs_pkt.src_0_a.data, obs_pkt.src_0_b.data);
    end
    tick();
    checks++;
    if (obs_pkt.is_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_dispatch_once got v=%b exp v=0", obs_pkt.is_valid);
    end
  endtask

  task automatic test_wakeup();
    instruction_t p;
    alu_rdy              = 1'b1;
    p                    = mk_pkt(ALU_SUB, 32'd9, 32'd0);
    p.src_0_b.is_renamed = 1'b1;
    p.src_0_b.tag        = 6'd3;
    rs_packet            = p;
    tick();
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        cdb[1].is_valid = 1'b1;
        cdb[1].dest_tag = 6'd3;
        cdb[1].result   = 32'h0000_0003;
      end
      tick();
      checks++;
      if (obs_pkt.is_valid !== 1'b0) begin
        errors++;
        $display("FAIL wakeup_wait c=%0d got v=%b exp v=0", c, obs_pkt.is_valid);
      end
    end
    drive_idle();
    tick();
    checks++;
    if (obs_pkt.is_valid !== 1'b1 || obs_pkt.src_0_b.data !== 32'h3 ||
        obs_pkt.src_0_b.is_renamed !== 1'b0 || obs_pkt.opcode !== ALU_SUB) begin
      errors++;
      $display("FAIL wakeup_issue got v=%b b=%h exp v=1 b=3", obs_pkt.is_valid, obs_pkt.src_0_b.data);
    end
  endtask

  task automatic test_bypass();
    instruction_t p;
    alu_rdy              = 1'b1;
    p                    = mk_pkt(ALU_XOR, 32'd1, 32'd2);
    p.src_1_a.is_renamed = 1'b1;
    p.src_1_a.tag        = 6'd5;
    rs_packet            = p;
    cdb[0].is_valid      = 1'b1;
    cdb[0].dest_tag      = 6'd5;
    cdb[0].result        = 32'hDEAD_BEEF;
    tick();
    drive_idle();
    tick();
    checks++;
    if (obs_pkt.is_valid !== 1'b1 || obs_pkt.src_1_a.data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass got v=%b d=%h exp v=1 d=deadbeef", obs_pkt.is_valid, obs_pkt.src_1_a.data);
    end
  endtask

  task automatic test_cdb_priority();
    instruction_t p;
    alu_rdy              = 1'b1;
    p                    = mk_pkt(ALU_OR, 32'd3, 32'd4);
    p.src_1_b.is_renamed = 1'b1;
    p.src_1_b.tag        = 6'd4;
    rs_packet            = p;
    tick();
    drive_idle();
    cdb[0].is_valid = 1'b1;
    cdb[0].dest_tag = 6'd4;
    cdb[0].result   = 32'h1111_1111;
    cdb[1].is_valid = 1'b1;
    cdb[1].dest_tag = 6'd4;
    cdb[1].result   = 32'h2222_2222;
    tick();
    drive_idle();
    tick();
    checks++;
    if (obs_pkt.is_valid !== 1'b1 || obs_pkt.src_1_b.data !== 32'h1111_1111) begin
      errors++;
      $display("FAIL cdb_priority got v=%b d=%h exp v=1 d=11111111", obs_pkt.is_valid, obs_pkt.src_1_b.data);
    end
  endtask

  task automatic test_full_order();
    alu_rdy = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      rs_packet = mk_pkt(ALU_ADD, 32'(i), 32'd0);
      tick();
    end
    rs_packet = mk_pkt(ALU_ADD, 32'd99, 32'd0);
    tick();
    checks++;
    if (obs_rdy !== 1'b0) begin
      errors++;
      $display("FAIL full_rdy got %b exp 0", obs_rdy);
    end
    drive_idle();
    alu_rdy = 1'b1;
    for (int i = 0; i < RS_DEPTH; i++) begin
      tick();
      checks++;
      if (obs_pkt.is_valid !== 1'b1 || obs_pkt.src_0_a.data !== 32'(i)) begin
        errors++;
        $display("FAIL order_%0d got v=%b a=%0d exp v=1 a=%0d", i, obs_pkt.is_valid, obs_pkt.src_0_a.data, i);
      end
    end
    tick();
    checks++;
    if (obs_rdy !== 1'b1 || obs_pkt.is_valid !== 1'b0) begin
      errors++;
      $display("FAIL drained got rdy=%b v=%b exp rdy=1 v=0", obs_rdy, obs_pkt.is_valid);
    end
  endtask

  task automatic test_age();
    instruction_t p;
    alu_rdy              = 1'b1;
    p                    = mk_pkt(ALU_BEQ, 32'hA, 32'd0);
    p.src_1_b.is_renamed = 1'b1;
    p.src_1_b.tag        = 6'd2;
    rs_packet            = p;
    tick();
    rs_packet = mk_pkt(ALU_AND, 32'hB, 32'd0);
    tick();
    drive_idle();
    tick();
    checks++;
    if (obs_pkt.is_valid !== 1'b1 || obs_pkt.src_0_a.data !== 32'hB) begin
      errors++;
      $display("FAIL age_b_first got v=%b a=%h exp v=1 a=b", obs_pkt.is_valid, obs_pkt.src_0_a.data);
    end
    cdb[0].is_valid = 1'b1;
    cdb[0].dest_tag = 6'd2;
    cdb[0].result   = 32'h22;
    tick();
    drive_idle();
    tick();
    checks++;
    if (obs_pkt.is_valid !== 1'b1 || obs_pkt.src_0_a.data !== 32'hA ||
        obs_pkt.src_1_b.data !== 32'h22) begin
      errors++;
      $display("FAIL age_a_after got v=%b a=%h d=%h exp v=1 a=a d=22",
               obs_pkt.is_valid, obs_pkt.src_0_a.data, obs_pkt.src_1_b.data);
    end
  endtask

  task automatic test_flush();
    instruction_t p;
    alu_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p = mk_pkt(ALU_ADD, 32'(i + 20), 32'd0);
      if (i >= 2) begin
        p.src_0_b.is_renamed = 1'b1;
        p.src_0_b.tag        = 6'(i + 4);
      end
      rs_packet = p;
      tick();
    end
    rs_packet = mk_pkt(ALU_SUB, 32'd77, 32'd0);
    flush     = 1'b1;
    alu_rdy   = 1'b1;
    tick();
    checks++;
    if (obs_pkt.is_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_issue got v=%b exp v=0", obs_pkt.is_valid);
    end
    drive_idle();
    tick();
    checks++;
    if (obs_pkt.is_valid !== 1'b0 || obs_rdy !== 1'b1) begin
      errors++;
      $display("FAIL after_flush got v=%b rdy=%b exp v=0 rdy=1", obs_pkt.is_valid, obs_rdy);
    end
    for (int t = 0; t < 8; t++) begin
      cdb[0].is_valid = 1'b1;
      cdb[0].dest_tag = 6'(t);
      cdb[0].result   = 32'(t);
      tick();
      checks++;
      if (obs_pkt.is_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_stale_%0d got v=%b exp v=0", t, obs_pkt.is_valid);
      end
    end
    drive_idle();
    tick();
    checks++;
    if (obs_pkt.is_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_stale_end got v=%b exp v=0", obs_pkt.is_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive_idle();
      rs_packet = ($urandom_range(0, 2) != 0) ? rand_pkt() : '0;
      alu_rdy   = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb[k].is_valid = $urandom_range(0, 1) == 1;
        cdb[k].dest_tag = 6'($urandom_range(0, 7));
        cdb[k].result   = $urandom;
      end
      flush = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      tick();
    end
    // Drain: broadcast every tag so waiting entries can leave
    drive_idle();
    alu_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cdb[0].is_valid = 1'b1;
      cdb[0].dest_tag = 6'(c % 8);
      cdb[0].result   = $urandom;
      tick();
    end
    drive_idle();
    tick();
    checks++;
    if (exp_q.size() != 0 || obs_rdy !== 1'b1) begin
      errors++;
      $display("FAIL random_drain got pending=%0d rdy=%b exp pending=0 rdy=1", exp_q.size(), obs_rdy);
    end
  endtask

  initial begin
    drive_idle();
    alu_rdy = 1'b0;
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_bypass();
    test_cdb_priority();
    test_full_order();
    test_age();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
